// File: rtl/uart_pkg.sv
// Shared types and character constants for the UART receive monitor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, frame FSM and mid-bit sample timing.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_e        r_state;
  rx_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_ferr;
  logic             w_ferr_nxt;
  logic             w_rx;
  logic             w_cnt_zero;

  assign w_rx       = r_sync2;
  assign w_cnt_zero = (r_cnt == '0);

  // Synchronizer resets to the idle-high level so a released reset never fakes a start bit.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync1   <= ser_rx;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_M1;
        end
      end
      START: begin
        if (w_cnt_zero) begin
          if (!w_rx) begin
            w_state_nxt   = DATA;
            w_cnt_nxt     = FULL_M1;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (w_cnt_zero) begin
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_cnt_nxt   = FULL_M1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (w_cnt_zero) begin
          if (w_rx) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_ferr  = r_ferr;
  assign rx_busy  = (r_state != IDLE);

endmodule

// File: rtl/uart_rx_monitor.sv
// UART receive monitor: byte receiver plus a line buffer that flags end-of-line.
module uart_rx_monitor
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4167,
  parameter int unsigned LINE_LEN     = 64
) (
  input  logic                             clock,
  input  logic                             resetb,
  input  logic                             ser_rx,
  output logic [7:0]                       rx_data,
  output logic                             rx_valid,
  output logic                             rx_ferr,
  output logic                             line_done,
  output logic [$clog2(LINE_LEN+1)-1:0]    line_count,
  output logic                             rx_busy
);

  localparam int unsigned PTR_W = $clog2(LINE_LEN + 1);
  localparam int unsigned IDX_W = $clog2(LINE_LEN);

  logic [7:0]       w_rx_data;
  logic             w_rx_valid;
  logic [PTR_W-1:0] r_wptr;
  logic [IDX_W-1:0] w_widx;
  logic             r_line_done;
  logic [PTR_W-1:0] r_line_count;
  logic [7:0]       r_buf [LINE_LEN];

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clock   (clock),
    .resetb  (resetb),
    .ser_rx  (ser_rx),
    .rx_data (w_rx_data),
    .rx_valid(w_rx_valid),
    .rx_ferr (rx_ferr),
    .rx_busy (rx_busy)
  );

  assign w_widx = r_wptr[IDX_W-1:0];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wptr       <= '0;
      r_line_done  <= 1'b0;
      r_line_count <= '0;
      for (int unsigned i = 0; i < LINE_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_line_done <= 1'b0;
      if (w_rx_valid) begin
        if (w_rx_data == CH_LF) begin
          r_line_done  <= 1'b1;
          r_line_count <= r_wptr;
          r_wptr       <= '0;
        end else if (w_rx_data != CH_CR) begin
          r_buf[w_widx] <= w_rx_data;
          // A full buffer closes the line itself; the next byte starts over at index 0.
          if (r_wptr == PTR_W'(LINE_LEN - 1)) begin
            r_line_done  <= 1'b1;
            r_line_count <= PTR_W'(LINE_LEN);
            r_wptr       <= '0;
          end else begin
            r_wptr <= r_wptr + PTR_W'(1);
          end
        end
      end
    end
  end

  assign rx_data    = w_rx_data;
  assign rx_valid   = w_rx_valid;
  assign line_done  = r_line_done;
  assign line_count = r_line_count;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Randomized bench for uart_rx_monitor against a byte/line-level reference model.
module tb_uart_rx_monitor;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic       clock  = 1'b0;
  logic       resetb = 1'b0;
  logic       ser_rx = 1'b1;

  logic [7:0] rx_data,  rx_data4;
  logic       rx_valid, rx_valid4;
  logic       rx_ferr,  rx_ferr4;
  logic       line_done, line_done4;
  logic [6:0] line_count;
  logic [2:0] line_count4;
  logic       rx_busy,  rx_busy4;

  uart_rx_monitor #(
    .CLKS_PER_BIT(CPB),
    .LINE_LEN    (64)
  ) u_dut (
    .clock     (clock),
    .resetb    (resetb),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .line_done (line_done),
    .line_count(line_count),
    .rx_busy   (rx_busy)
  );

  uart_rx_monitor #(
    .CLKS_PER_BIT(CPB),
    .LINE_LEN    (4)
  ) u_dut4 (
    .clock     (clock),
    .resetb    (resetb),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data4),
    .rx_valid  (rx_valid4),
    .rx_ferr   (rx_ferr4),
    .line_done (line_done4),
    .line_count(line_count4),
    .rx_busy   (rx_busy4)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          ferr;
    logic [7:0]  data;
    int unsigned t0;
  } ev_t;

  ev_t        evq[$];
  int         lq64[$];
  int         lq4[$];
  logic [7:0] mbuf64 [64];
  logic [7:0] mbuf4  [4];
  int         mp64, mp4;
  logic [7:0] last_good;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    lq64.delete();
    lq4.delete();
    for (int i = 0; i < 64; i++) mbuf64[i] = '0;
    for (int i = 0; i < 4; i++) mbuf4[i] = '0;
    mp64 = 0;
    mp4 = 0;
    last_good = '0;
  endtask

  // Line rules: LF closes the line, CR vanishes, anything else is stored; a full buffer closes too.
  task automatic model_line(input logic [7:0] b);
    if (b == CH_LF) begin
      lq64.push_back(mp64);
      mp64 = 0;
      lq4.push_back(mp4);
      mp4 = 0;
    end else if (b != CH_CR) begin
      mbuf64[mp64] = b;
      mp64++;
      if (mp64 == 64) begin
        lq64.push_back(64);
        mp64 = 0;
      end
      mbuf4[mp4] = b;
      mp4++;
      if (mp4 == 4) begin
        lq4.push_back(4);
        mp4 = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    ser_rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  // Called at a negedge; returns at a negedge with the line back high so frames can abut.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    ev_t e;
    e.ferr = !stop_ok;
    e.data = stop_ok ? b : last_good;
    e.t0   = cyc;
    if (stop_ok) begin
      last_good = b;
      model_line(b);
    end
    evq.push_back(e);
    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (CPB) @(negedge clock);
      if (i == 3) chk("busy_mid", {31'b0, rx_busy}, 1);
    end
    ser_rx = stop_ok;
    repeat (CPB) @(negedge clock);
    ser_rx = 1'b1;
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 64; i++)
      chk($sformatf("%s_buf64[%0d]", tag, i), {24'b0, u_dut.r_buf[i]}, {24'b0, mbuf64[i]});
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_buf4[%0d]", tag, i), {24'b0, u_dut4.r_buf[i]}, {24'b0, mbuf4[i]});
    chk({tag, "_wptr64"}, 32'(u_dut.r_wptr), 32'(mp64));
    chk({tag, "_wptr4"}, 32'(u_dut4.r_wptr), 32'(mp4));
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_pending_bytes"}, 32'(evq.size()), 0);
    chk({tag, "_pending_lines64"}, 32'(lq64.size()), 0);
    chk({tag, "_pending_lines4"}, 32'(lq4.size()), 0);
  endtask

  task automatic do_reset(input string tag);
    check_drained(tag);
    resetb = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    chk({tag, "_rst_rx_data"}, {24'b0, rx_data}, 0);
    chk({tag, "_rst_rx_valid"}, {31'b0, rx_valid}, 0);
    chk({tag, "_rst_rx_ferr"}, {31'b0, rx_ferr}, 0);
    chk({tag, "_rst_line_done"}, {31'b0, line_done}, 0);
    chk({tag, "_rst_line_count"}, {25'b0, line_count}, 0);
    chk({tag, "_rst_rx_busy"}, {31'b0, rx_busy}, 0);
    chk({tag, "_rst_wptr"}, 32'(u_dut.r_wptr), 0);
    resetb = 1'b1;
    @(negedge clock);
  endtask

  // Strobe monitor: every strobe must match the oldest outstanding expectation.
  ev_t         me;
  int unsigned lat;
  always @(negedge clock) begin
    if (resetb) begin
      if (rx_valid || rx_ferr) begin
        chk("valid_ferr_exclusive", {31'b0, rx_valid & rx_ferr}, 0);
        if (evq.size() == 0) begin
          chk("unexpected_strobe", {30'b0, rx_valid, rx_ferr}, 0);
        end else begin
          me = evq.pop_front();
          chk("strobe_valid", {31'b0, rx_valid}, {31'b0, !me.ferr});
          chk("strobe_ferr", {31'b0, rx_ferr}, {31'b0, me.ferr});
          chk("strobe_rx_data", {24'b0, rx_data}, {24'b0, me.data});
          chk("busy_after_stop", {31'b0, rx_busy}, 0);
          lat = cyc - me.t0;
          chk($sformatf("latency_%0d_in_window", lat), {31'b0, (lat >= 148 && lat <= 160)}, 1);
        end
      end
      if (line_done) begin
        if (lq64.size() == 0) chk("unexpected_line_done64", {31'b0, line_done}, 0);
        else chk("line_count64", {25'b0, line_count}, 32'(lq64.pop_front()));
      end
      if (line_done4) begin
        if (lq4.size() == 0) chk("unexpected_line_done4", {31'b0, line_done4}, 0);
        else chk("line_count4", {29'b0, line_count4}, 32'(lq4.pop_front()));
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg1 [6];
    logic [7:0] msg2 [5];
    logic [7:0] b;
    bit         ok;
    int         r;

    msg1 = '{8'h41, 8'h42, 8'h34, 8'h30, 8'h0D, 8'h0A};
    msg2 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

    resetb = 1'b0;
    ser_rx = 1'b1;
    @(negedge clock);
    do_reset("init");
    idle(4);

    send_frame(8'h55, 1'b1);
    idle(CPB);
    chk("hold_0x55", {24'b0, rx_data}, 32'h55);

    for (int i = 0; i < 6; i++) send_frame(msg1[i], 1'b1);
    idle(CPB);
    check_drained("ab40");
    check_buf("ab40");

    send_frame(8'hA3, 1'b0);
    idle(2 * CPB);
    chk("ferr_keeps_rx_data", {24'b0, rx_data}, {24'b0, last_good});
    chk("ferr_wptr", 32'(u_dut.r_wptr), 32'(mp64));

    ser_rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(CPB);
    chk("glitch_busy", {31'b0, rx_busy}, 0);
    send_frame(8'h3E, 1'b1);
    idle(CPB);
    chk("after_glitch", {24'b0, rx_data}, 32'h3E);

    ser_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    ser_rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    chk("abort_busy_mid_data", {31'b0, rx_busy}, 1);
    do_reset("abort");
    idle(10 * CPB);
    send_frame(8'h44, 1'b1);
    idle(CPB);
    chk("after_abort", {24'b0, rx_data}, 32'h44);

    do_reset("wrap");
    for (int i = 0; i < 5; i++) send_frame(msg2[i], 1'b1);
    idle(CPB);
    check_drained("wrap");
    check_buf("wrap");

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 15));
      if (r == 0)      b = CH_LF;
      else if (r == 1) b = CH_CR;
      else             b = 8'($urandom_range(32, 126));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok);
      if (!ok) idle(2 * CPB);
      else     idle(int'($urandom_range(0, 20)));
    end
    idle(2 * CPB);
    check_drained("random");
    check_buf("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
